atcaxi2tluh500_rr_arb: RTL and testbench

ATCAXI2TLUH500_RR_ARB -- requirements
Module: atcaxi2tluh500_rr_arb

---
 rtl/atcaxi2tluh500_rr_arb_pkg.sv | 21 ++
 rtl/atcaxi2tluh500_mux_onehot.sv | 23 ++
 rtl/atcaxi2tluh500_rr_arb.sv | 138 +++++++++++++
 tb/tb_atcaxi2tluh500_rr_arb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/atcaxi2tluh500_rr_arb_pkg.sv
// Shared helpers for the round-robin packet arbiter.
// oh2idx turns a one-hot grant into the index of its set bit.
package atcaxi2tluh500_rr_arb_pkg;

  localparam int MAX_N = 16;

  // Returns the index of a one-hot vector; an all-zero input returns 0.
  function automatic logic [3:0] oh2idx(input logic [MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) begin
        idx = idx | 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/atcaxi2tluh500_mux_onehot.sv
// One-hot selected payload multiplexer: ORs together every slice whose select bit is set.
module atcaxi2tluh500_mux_onehot #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] in,
  output logic [W-1:0]   out
);

  // AND-OR selection of the granted requester's payload.
  always_comb begin
    out = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        out = out | in[i*W +: W];
      end else begin
        out = out;
      end
    end
  end

endmodule

// File: rtl/atcaxi2tluh500_rr_arb.sv
// Packet-granular round-robin arbiter with a single registered output stage.
// A requester keeps the grant from its first beat until its last beat is accepted.
module atcaxi2tluh500_rr_arb
  import atcaxi2tluh500_rr_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic           out_last,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_grant,
  input  logic           out_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  r_ptr;
  logic [N-1:0]   r_lock_oh;
  logic           r_out_valid;
  logic           r_out_last;
  logic [W-1:0]   r_out_data;
  logic [N-1:0]   r_out_grant;

  logic           w_load;
  logic           w_locked;
  logic [2*N-1:0] w_dbl_req;
  logic [N-1:0]   w_rot_req;
  logic [N-1:0]   w_rot_first;
  logic [2*N-1:0] w_dbl_gnt;
  logic [N-1:0]   w_rr_gnt;
  logic [N-1:0]   w_gnt;
  logic           w_xfer;
  logic           w_sel_last;
  logic [W-1:0]   w_sel_data;
  logic [3:0]     w_gidx;
  logic [PW-1:0]  w_ptr_nxt;

  assign w_load   = ~r_out_valid | out_ready;
  assign w_locked = |r_lock_oh;

  // Rotate requests so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    w_dbl_req   = {req_valid, req_valid} >> r_ptr;
    w_rot_req   = w_dbl_req[N-1:0];
    w_rot_first = w_rot_req & (~w_rot_req + N'(1));
    w_dbl_gnt   = {w_rot_first, w_rot_first} << r_ptr;
    w_rr_gnt    = w_dbl_gnt[2*N-1:N];
  end

  // A locked requester is the only candidate; it stalls the output while it is idle.
  always_comb begin
    if (w_locked) begin
      w_gnt = r_lock_oh & req_valid;
    end else begin
      w_gnt = w_rr_gnt;
    end
  end

  assign req_ready  = {N{w_load}} & w_gnt;
  assign w_xfer     = w_load & (|w_gnt);
  assign w_sel_last = |(req_last & w_gnt);
  assign w_gidx     = oh2idx(16'(w_gnt));

  // Pointer moves to the requester after the one whose packet just ended.
  always_comb begin
    if (w_gidx >= 4'(N - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = PW'(w_gidx + 4'd1);
    end
  end

  atcaxi2tluh500_mux_onehot #(
    .N (N),
    .W (W)
  ) u_mux (
    .sel (w_gnt),
    .in  (req_data),
    .out (w_sel_data)
  );

  // Lock and pointer tracking at packet boundaries.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ptr     <= '0;
      r_lock_oh <= '0;
    end else if (w_xfer) begin
      if (w_sel_last) begin
        r_ptr     <= w_ptr_nxt;
        r_lock_oh <= '0;
      end else begin
        r_ptr     <= r_ptr;
        r_lock_oh <= w_gnt;
      end
    end else begin
      r_ptr     <= r_ptr;
      r_lock_oh <= r_lock_oh;
    end
  end

  // Output stage: load a new beat, go idle on an empty load, or hold under backpressure.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_grant <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_sel_last;
      r_out_data  <= w_sel_data;
      r_out_grant <= w_gnt;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
      r_out_last  <= r_out_last;
      r_out_data  <= r_out_data;
      r_out_grant <= r_out_grant;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_last  <= r_out_last;
      r_out_data  <= r_out_data;
      r_out_grant <= r_out_grant;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign out_grant = r_out_grant;

endmodule

// File: tb/tb_atcaxi2tluh500_rr_arb.sv
// Directed and randomized bench for the round-robin arbiter (N=4, W=8), with a
// behavioural model that scans requesters from a pointer and tracks the packet owner.
module tb_atcaxi2tluh500_rr_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_last;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_grant;
  logic           out_ready;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // model state
  int         m_ptr;
  int         m_lock;
  logic       m_ov;
  logic       m_ol;
  logic [7:0] m_od;
  logic [3:0] m_og;

  int wait_pk [N];
  bit fair_on = 1'b0;

  always #5 aclk = ~aclk;

  atcaxi2tluh500_rr_arb #(.N(N), .W(W)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_grant (out_grant),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_lock = -1;
    m_ov   = 1'b0;
    m_ol   = 1'b0;
    m_od   = 8'h00;
    m_og   = 4'b0000;
    for (int i = 0; i < N; i++) wait_pk[i] = 0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".out_last"},  32'(out_last),  32'(m_ol));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_od));
    chk({tag, ".out_grant"}, 32'(out_grant), 32'(m_og));
  endtask

  // One clock cycle: drive inputs, check req_ready, advance the model, check outputs.
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                      input logic ordy, input string tag);
    bit         load;
    int         g;
    logic [3:0] exp_rdy;
    logic [3:0] xfer;
    bit         pkt_end;
    bit         fair_ok;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    out_ready = ordy;
    #1;
    load = !m_ov || ordy;
    g = -1;
    if (m_lock >= 0) begin
      if (v[m_lock]) g = m_lock;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
    if (fair_on) begin
      chk({tag, ".onehot0"}, 32'($onehot0(req_ready)), 32'd1);
      xfer    = req_valid & req_ready;
      pkt_end = |(xfer & req_last);
      fair_ok = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || xfer[i]) wait_pk[i] = 0;
        else if (pkt_end) wait_pk[i]++;
        if (wait_pk[i] > N - 1) fair_ok = 1'b0;
      end
      chk({tag, ".fairness"}, 32'(fair_ok), 32'd1);
    end
    if (load) begin
      if (g >= 0) begin
        m_ov = 1'b1;
        m_od = d[g*8 +: 8];
        m_ol = l[g];
        m_og = 4'(1 << g);
        if (l[g]) begin
          m_lock = -1;
          m_ptr  = (g + 1) % N;
        end else begin
          m_lock = g;
        end
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge aclk);
    #1;
    chk_outputs(tag);
  endtask

  initial begin
    aresetn   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk_outputs("reset");
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // All four valid with single-beat packets: grants rotate 0,1,2,3,0.
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 4'b1111, 32'h4433_2211 + 32'(c), 1'b1, "rr");
      chk("rr.grant_order", 32'(out_grant), 32'(1 << (c % N)));
    end

    // Requester 1 single beat moves the pointer to 2; then a 3-beat packet from 2.
    step(4'b0010, 4'b0010, 32'h0000_1500, 1'b1, "pre");
    step(4'b0110, 4'b0000, 32'h0021_1600, 1'b1, "pkt0");
    chk("pkt.b0", 32'(out_data), 32'h21);
    step(4'b0110, 4'b0000, 32'h0022_1700, 1'b1, "pkt1");
    chk("pkt.b1", 32'(out_data), 32'h22);
    step(4'b0110, 4'b0100, 32'h0023_1800, 1'b1, "pkt2");
    chk("pkt.b2", 32'(out_data), 32'h23);
    chk("pkt.grant", 32'(out_grant), 32'h4);
    step(4'b0010, 4'b0010, 32'h0000_1900, 1'b1, "pkt_after");
    chk("pkt.next_grant", 32'(out_grant), 32'h2);

    // Backpressure for 5 cycles, then drain and reload on the same edge.
    step(4'b1000, 4'b0000, 32'h3A00_0000, 1'b1, "bp_load");
    for (int c = 0; c < 5; c++) step(4'b1001, 4'b1001, 32'h3B00_00C0, 1'b0, "bp_hold");
    step(4'b1001, 4'b1001, 32'h3C00_00C1, 1'b1, "bp_drain");

    // Locked requester 0 goes idle while requester 3 waits.
    step(4'b0001, 4'b0000, 32'h0000_0050, 1'b1, "lk0");
    step(4'b1000, 4'b1000, 32'h5100_0000, 1'b1, "lk_gap0");
    chk("lk.gap_valid", 32'(out_valid), 32'd0);
    step(4'b1000, 4'b1000, 32'h5200_0000, 1'b1, "lk_gap1");
    step(4'b1001, 4'b1001, 32'h5300_0053, 1'b1, "lk_resume");
    chk("lk.resume_grant", 32'(out_grant), 32'h1);

    // Build lock=2, ptr=3, then reset mid-packet.
    step(4'b0100, 4'b0100, 32'h0060_0000, 1'b1, "rs_p");
    step(4'b0100, 4'b0000, 32'h0061_0000, 1'b1, "rs_lk");
    aresetn = 1'b0;
    #1;
    model_reset();
    chk_outputs("rs_async");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step(4'b1100, 4'b1100, 32'h7071_0000, 1'b1, "rs_first");
    chk("rs.first_grant", 32'(out_grant), 32'h4);

    // Random traffic against the model.
    fair_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      step(4'($urandom_range(0, 15)),
           {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)},
           $urandom, 1'($urandom_range(0, 3) != 0), "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
